// File: rtl/ins_decode_stage.sv
// MIPS decode stage with integrated ID/EX register, prioritised operand forwarding,
// load-use stall detection and valid/ready handshakes on both sides.
module ins_decode_stage #(
    parameter int DATA_W   = 32,
    parameter int RADDR_W  = 5,
    parameter int FWD_N    = 2,
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_pc,
    input  logic [31:0]                in_ins,
    input  logic                       flush,
    output logic                       rf_re1,
    output logic                       rf_re2,
    output logic [RADDR_W-1:0]         rf_addr1,
    output logic [RADDR_W-1:0]         rf_addr2,
    input  logic [DATA_W-1:0]          rf_data1,
    input  logic [DATA_W-1:0]          rf_data2,
    input  logic [FWD_N-1:0]           fwd_we,
    input  logic [FWD_N*RADDR_W-1:0]   fwd_addr,
    input  logic [FWD_N*DATA_W-1:0]    fwd_data,
    input  logic                       ld_valid,
    input  logic [RADDR_W-1:0]         ld_addr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_pc,
    output logic [ALUOP_W-1:0]         out_aluop,
    output logic [ALUSEL_W-1:0]        out_alusel,
    output logic [DATA_W-1:0]          out_op1,
    output logic [DATA_W-1:0]          out_op2,
    output logic [RADDR_W-1:0]         out_waddr,
    output logic                       out_we,
    output logic                       out_illegal,
    output logic [15:0]                stall_cnt
);

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;
    localparam logic [5:0] F_SYNC = 6'h0F;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;

    localparam logic [ALUOP_W-1:0] ALU_NOP = ALUOP_W'(8'h00);
    localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(8'h24);
    localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(8'h25);
    localparam logic [ALUOP_W-1:0] ALU_XOR = ALUOP_W'(8'h26);
    localparam logic [ALUOP_W-1:0] ALU_NOR = ALUOP_W'(8'h27);
    localparam logic [ALUOP_W-1:0] ALU_SLL = ALUOP_W'(8'h7C);
    localparam logic [ALUOP_W-1:0] ALU_SRL = ALUOP_W'(8'h02);
    localparam logic [ALUOP_W-1:0] ALU_SRA = ALUOP_W'(8'h03);

    localparam logic [ALUSEL_W-1:0] SEL_NOP   = ALUSEL_W'(3'b000);
    localparam logic [ALUSEL_W-1:0] SEL_LOGIC = ALUSEL_W'(3'b001);
    localparam logic [ALUSEL_W-1:0] SEL_SHIFT = ALUSEL_W'(3'b010);

    logic [5:0]          opcode, funct;
    logic [RADDR_W-1:0]  rs, rt, rd;
    logic [DATA_W-1:0]   imm_zext, sa_zext;

    logic [ALUOP_W-1:0]  dec_aluop;
    logic [ALUSEL_W-1:0] dec_alusel;
    logic                dec_re1, dec_re2, dec_wreq, dec_illegal;
    logic [RADDR_W-1:0]  dec_waddr;
    logic [DATA_W-1:0]   dec_imm1, dec_imm2;
    logic [DATA_W-1:0]   sel_op1, sel_op2;

    logic stall, slot_free, transfer;

    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_pc_q, out_pc_d;
    logic [ALUOP_W-1:0]  out_aluop_q, out_aluop_d;
    logic [ALUSEL_W-1:0] out_alusel_q, out_alusel_d;
    logic [DATA_W-1:0]   out_op1_q, out_op1_d;
    logic [DATA_W-1:0]   out_op2_q, out_op2_d;
    logic [RADDR_W-1:0]  out_waddr_q, out_waddr_d;
    logic                out_we_q, out_we_d;
    logic                out_illegal_q, out_illegal_d;
    logic [15:0]         stall_cnt_q, stall_cnt_d;

    assign opcode   = in_ins[31:26];
    assign funct    = in_ins[5:0];
    assign rs       = RADDR_W'(in_ins[25:21]);
    assign rt       = RADDR_W'(in_ins[20:16]);
    assign rd       = RADDR_W'(in_ins[15:11]);
    assign imm_zext = DATA_W'(in_ins[15:0]);
    assign sa_zext  = DATA_W'(in_ins[10:6]);

    // Youngest matching forward source wins; register 0 is never forwarded.
    function automatic logic [DATA_W-1:0] pick_operand(
        input logic [RADDR_W-1:0]       addr,
        input logic [DATA_W-1:0]        rf_val,
        input logic [FWD_N-1:0]         we,
        input logic [FWD_N*RADDR_W-1:0] faddr,
        input logic [FWD_N*DATA_W-1:0]  fdata
    );
        logic [DATA_W-1:0] val;
        logic              hit;
        hit = 1'b0;
        val = (addr == '0) ? '0 : rf_val;
        for (int i = 0; i < FWD_N; i++) begin
            if (!hit && addr != '0 && we[i] && faddr[i*RADDR_W +: RADDR_W] == addr) begin
                val = fdata[i*DATA_W +: DATA_W];
                hit = 1'b1;
            end
        end
        return val;
    endfunction

    always_comb begin
        dec_aluop   = ALU_NOP;
        dec_alusel  = SEL_NOP;
        dec_re1     = 1'b0;
        dec_re2     = 1'b0;
        dec_wreq    = 1'b0;
        dec_illegal = 1'b0;
        dec_waddr   = '0;
        dec_imm1    = '0;
        dec_imm2    = '0;
        if (in_ins != 32'd0) begin
            case (opcode)
                OP_ORI, OP_ANDI, OP_XORI: begin
                    dec_aluop  = (opcode == OP_ORI)  ? ALU_OR :
                                 (opcode == OP_ANDI) ? ALU_AND : ALU_XOR;
                    dec_alusel = SEL_LOGIC;
                    dec_re1    = 1'b1;
                    dec_imm2   = imm_zext;
                    dec_waddr  = rt;
                    dec_wreq   = 1'b1;
                end
                OP_LUI: begin
                    dec_aluop  = ALU_OR;
                    dec_alusel = SEL_LOGIC;
                    dec_imm1   = imm_zext << 16;
                    dec_waddr  = rt;
                    dec_wreq   = 1'b1;
                end
                OP_SPECIAL: begin
                    case (funct)
                        F_AND, F_OR, F_XOR, F_NOR: begin
                            dec_aluop  = (funct == F_AND) ? ALU_AND :
                                         (funct == F_OR)  ? ALU_OR  :
                                         (funct == F_XOR) ? ALU_XOR : ALU_NOR;
                            dec_alusel = SEL_LOGIC;
                            dec_re1    = 1'b1;
                            dec_re2    = 1'b1;
                            dec_waddr  = rd;
                            dec_wreq   = 1'b1;
                        end
                        F_SLLV, F_SRLV, F_SRAV: begin
                            dec_aluop  = (funct == F_SLLV) ? ALU_SLL :
                                         (funct == F_SRLV) ? ALU_SRL : ALU_SRA;
                            dec_alusel = SEL_SHIFT;
                            dec_re1    = 1'b1;
                            dec_re2    = 1'b1;
                            dec_waddr  = rd;
                            dec_wreq   = 1'b1;
                        end
                        F_SLL, F_SRL, F_SRA: begin
                            dec_aluop  = (funct == F_SLL) ? ALU_SLL :
                                         (funct == F_SRL) ? ALU_SRL : ALU_SRA;
                            dec_alusel = SEL_SHIFT;
                            dec_re2    = 1'b1;
                            dec_imm1   = sa_zext;
                            dec_waddr  = rd;
                            dec_wreq   = 1'b1;
                        end
                        F_SYNC: ;
                        default: dec_illegal = 1'b1;
                    endcase
                end
                default: dec_illegal = 1'b1;
            endcase
        end
    end

    always_comb begin
        sel_op1 = dec_re1 ? pick_operand(rs, rf_data1, fwd_we, fwd_addr, fwd_data) : dec_imm1;
        sel_op2 = dec_re2 ? pick_operand(rt, rf_data2, fwd_we, fwd_addr, fwd_data) : dec_imm2;
    end

    assign rf_re1   = dec_re1;
    assign rf_re2   = dec_re2;
    assign rf_addr1 = rs;
    assign rf_addr2 = rt;

    assign stall     = in_valid && ld_valid && ld_addr != '0 &&
                       ((dec_re1 && ld_addr == rs) || (dec_re2 && ld_addr == rt));
    assign slot_free = !out_valid_q || out_ready;
    // A flush drains the held input, so the fetch side sees ready even when stalled.
    assign in_ready  = !rst && (flush || (slot_free && !stall));
    assign transfer  = in_valid && in_ready && !flush;

    always_comb begin
        out_valid_d   = out_valid_q;
        out_pc_d      = out_pc_q;
        out_aluop_d   = out_aluop_q;
        out_alusel_d  = out_alusel_q;
        out_op1_d     = out_op1_q;
        out_op2_d     = out_op2_q;
        out_waddr_d   = out_waddr_q;
        out_we_d      = out_we_q;
        out_illegal_d = out_illegal_q;
        stall_cnt_d   = stall_cnt_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (transfer) begin
            out_valid_d   = 1'b1;
            out_pc_d      = in_pc;
            out_aluop_d   = dec_aluop;
            out_alusel_d  = dec_alusel;
            out_op1_d     = sel_op1;
            out_op2_d     = sel_op2;
            out_waddr_d   = dec_waddr;
            out_we_d      = dec_wreq && dec_waddr != '0;
            out_illegal_d = dec_illegal;
        end else if (slot_free) begin
            out_valid_d = 1'b0;
        end
        if (stall && !flush && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            out_pc_q      <= '0;
            out_aluop_q   <= '0;
            out_alusel_q  <= '0;
            out_op1_q     <= '0;
            out_op2_q     <= '0;
            out_waddr_q   <= '0;
            out_we_q      <= 1'b0;
            out_illegal_q <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_pc_q      <= out_pc_d;
            out_aluop_q   <= out_aluop_d;
            out_alusel_q  <= out_alusel_d;
            out_op1_q     <= out_op1_d;
            out_op2_q     <= out_op2_d;
            out_waddr_q   <= out_waddr_d;
            out_we_q      <= out_we_d;
            out_illegal_q <= out_illegal_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_pc      = out_pc_q;
    assign out_aluop   = out_aluop_q;
    assign out_alusel  = out_alusel_q;
    assign out_op1     = out_op1_q;
    assign out_op2     = out_op2_q;
    assign out_waddr   = out_waddr_q;
    assign out_we      = out_we_q;
    assign out_illegal = out_illegal_q;
    assign stall_cnt   = stall_cnt_q;

endmodule
